// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the 128-bit line interface used by the cache
//   hierarchy. Serves one line request at a time with a fixed, programmable
//   latency and keeps lines in an internal array of 2**ADDR_BITS entries.
//
//   A request seen in IDLE in cycle c0 completes with a single mem_ready pulse
//   in cycle c0+LATENCY, followed by one HOLD cycle in which requests are
//   ignored. The requester registers mem_ready, so it still shows the old
//   request level during HOLD.
//
// Parameters
//   LATENCY    cycles from request-visible cycle to mem_ready (1..255)
//   ADDR_BITS  line-index bits taken from mem_addr
//   CNT_W      width of the saturating read/write completion counters
//
// Ports
//   clk         in   1       clock, rising edge
//   proc_reset  in   1       asynchronous active-high reset
//   mem_read    in   1       line read request (level, held until ready)
//   mem_write   in   1       line write request (level, held until ready)
//   mem_addr    in   28      line address, only [ADDR_BITS-1:0] used
//   mem_wdata   in   128     write line data, sampled with the request
//   mem_rdata   out  128     read line data, registered, holds until next read
//   mem_ready   out  1       one-cycle completion pulse
//   proto_err   out  1       sticky: read and write both high in IDLE
//   rd_cnt      out  CNT_W   completed reads, saturating
//   wr_cnt      out  CNT_W   completed writes, saturating
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int LATENCY   = 8,
    parameter int ADDR_BITS = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [27:0]      mem_addr,
    input  logic [127:0]     mem_wdata,
    output logic [127:0]     mem_rdata,
    output logic             mem_ready,
    output logic             proto_err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int         DEPTH      = 1 << ADDR_BITS;
    localparam logic [7:0] LAT_M1     = 8'(LATENCY - 1);
    localparam bit         LAT_IS_ONE = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   op_write_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [127:0]           wdata_q;
    logic [127:0]           mem_rdata_q;
    logic                   mem_ready_q;
    logic                   proto_err_q;
    logic [CNT_W-1:0]       rd_cnt_q;
    logic [CNT_W-1:0]       wr_cnt_q;
    logic [127:0]           mem_array_q [0:DEPTH-1];

    logic                   req_s;
    logic                   accept_s;
    logic                   resp_entry_s;
    logic                   eff_write_s;
    logic [ADDR_BITS-1:0]   eff_idx_s;
    logic [127:0]           eff_wdata_s;
    logic                   unused_addr_s;

    // Upper address bits alias onto the same line; they are deliberately dropped.
    assign unused_addr_s = ^mem_addr[27:ADDR_BITS];

    assign req_s    = mem_read | mem_write;
    assign accept_s = (state_q == IDLE) && req_s;

    // Next-state and latency countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (LAT_IS_ONE) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                    cnt_d = LAT_M1;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = RESP;
                end else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                state_d = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operation seen at RESP entry: with LATENCY=1 entry happens on the same
    // edge that accepts the request, so the live inputs must be used directly.
    always_comb begin
        if (state_q == IDLE) begin
            eff_write_s = mem_write;
            eff_idx_s   = mem_addr[ADDR_BITS-1:0];
            eff_wdata_s = mem_wdata;
        end else begin
            eff_write_s = op_write_q;
            eff_idx_s   = addr_q;
            eff_wdata_s = wdata_q;
        end
    end

    assign resp_entry_s = (state_d == RESP) && (state_q != RESP);

    // Control, capture, read data, flags and counters. The array sits in the
    // non-reset branch so that no write can land while reset is asserted.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 128'd0;
            mem_rdata_q <= 128'd0;
            mem_ready_q <= 1'b0;
            proto_err_q <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            // mem_ready is high exactly while state_q is RESP.
            mem_ready_q <= resp_entry_s;

            if (accept_s) begin
                // Write wins when both are requested.
                op_write_q <= mem_write;
                addr_q     <= mem_addr[ADDR_BITS-1:0];
                wdata_q    <= mem_wdata;
            end

            if (accept_s && mem_read && mem_write) begin
                proto_err_q <= 1'b1;
            end

            if (resp_entry_s) begin
                if (eff_write_s) begin
                    mem_array_q[eff_idx_s] <= eff_wdata_s;
                end else begin
                    mem_rdata_q <= mem_array_q[eff_idx_s];
                end
            end

            if (state_q == RESP) begin
                if (op_write_q) begin
                    wr_cnt_q <= sat_inc(wr_cnt_q);
                end else begin
                    rd_cnt_q <= sat_inc(rd_cnt_q);
                end
            end
        end
    end

    assign mem_rdata = mem_rdata_q;
    assign mem_ready = mem_ready_q;
    assign proto_err = proto_err_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    localparam logic [127:0] D3 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [127:0] D4 = 128'hA0A0A0A0_5555AAAA_0F0F0F0F_00000001;
    localparam logic [127:0] D5 = 128'h33333333_44444444_55555555_66666666;
    localparam logic [127:0] D6 = 128'h10101010_20202020_30303030_40404040;
    localparam logic [127:0] D7 = 128'h77777777_88888888_99999999_AAAAAAAA;

    logic clk;
    logic rst_a, rst_b;

    // Instance A: LATENCY=8, ADDR_BITS=8, CNT_W=16
    logic          a_read, a_write;
    logic [27:0]   a_addr;
    logic [127:0]  a_wdata, a_rdata;
    logic          a_ready, a_perr;
    logic [15:0]   a_rd_cnt, a_wr_cnt;

    // Instance B: LATENCY=1, CNT_W=4
    logic          b_read, b_write;
    logic [27:0]   b_addr;
    logic [127:0]  b_wdata, b_rdata;
    logic          b_ready, b_perr;
    logic [3:0]    b_rd_cnt, b_wr_cnt;

    int checks = 0;
    int errors = 0;
    int a_pulses = 0;
    int b_pulses = 0;

    mem_responder #(.LATENCY(8), .ADDR_BITS(8), .CNT_W(16)) u_a (
        .clk(clk), .proc_reset(rst_a), .mem_read(a_read), .mem_write(a_write),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
        .mem_ready(a_ready), .proto_err(a_perr), .rd_cnt(a_rd_cnt), .wr_cnt(a_wr_cnt)
    );

    mem_responder #(.LATENCY(1), .ADDR_BITS(8), .CNT_W(4)) u_b (
        .clk(clk), .proc_reset(rst_b), .mem_read(b_read), .mem_write(b_write),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
        .mem_ready(b_ready), .proto_err(b_perr), .rd_cnt(b_rd_cnt), .wr_cnt(b_wr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (a_ready) a_pulses++;
        if (b_ready) b_pulses++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request: drive in an IDLE cycle, measure cycles to mem_ready, drop
    // the request, confirm the HOLD cycle has no pulse, end back in IDLE.
    task automatic req(input bit sel_b, input logic rd, input logic wr,
                       input logic [27:0] addr, input logic [127:0] wd,
                       input int exp_lat, input string tag);
        int   lat;
        logic rdy;
        @(negedge clk);
        if (sel_b) begin
            b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd;
        end else begin
            a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
        end
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            rdy = sel_b ? b_ready : a_ready;
        end
        chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
        if (sel_b) begin
            b_read = 1'b0; b_write = 1'b0;
        end else begin
            a_read = 1'b0; a_write = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, " hold_ready"}, 128'(sel_b ? b_ready : a_ready), 128'(0));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int   exp_rd, exp_wr, p0;
        logic exp_perr;

        vecs[0]  = '{1'b0, 1'b1, 28'h0000005, D1, 128'd0};
        vecs[1]  = '{1'b1, 1'b0, 28'h0000005, D7, D1};
        vecs[2]  = '{1'b0, 1'b1, 28'h00000FF, D2, D1};
        vecs[3]  = '{1'b0, 1'b1, 28'h0000000, D3, D1};
        vecs[4]  = '{1'b1, 1'b0, 28'h00000FF, D7, D2};
        vecs[5]  = '{1'b1, 1'b0, 28'h0000000, D7, D3};
        vecs[6]  = '{1'b0, 1'b1, 28'h10000A0, D4, D3};
        vecs[7]  = '{1'b1, 1'b0, 28'h00000A0, D7, D4};
        vecs[8]  = '{1'b1, 1'b0, 28'hFFFFF05, D7, D1};
        vecs[9]  = '{1'b1, 1'b1, 28'h0000033, D5, D1};
        vecs[10] = '{1'b1, 1'b0, 28'h0000033, D7, D5};
        vecs[11] = '{1'b0, 1'b1, 28'h0000010, D6, D5};

        a_read = 1'b0; a_write = 1'b0; a_addr = 28'd0; a_wdata = 128'd0;
        b_read = 1'b0; b_write = 1'b0; b_addr = 28'd0; b_wdata = 128'd0;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        rst_a = 1'b1; rst_b = 1'b1;
        #1;
        chk("reset ready", 128'(a_ready), 128'(0));
        chk("reset rdata", a_rdata, 128'd0);
        chk("reset proto_err", 128'(a_perr), 128'(0));
        chk("reset rd_cnt", 128'(a_rd_cnt), 128'(0));
        chk("reset wr_cnt", 128'(a_wr_cnt), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Table-driven sequence on instance A
        exp_rd = 0; exp_wr = 0; exp_perr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            req(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 8,
                $sformatf("vec%0d", i));
            if (vecs[i].wr) exp_wr++;
            else            exp_rd++;
            if (vecs[i].rd && vecs[i].wr) exp_perr = 1'b1;
            chk($sformatf("vec%0d rdata", i), a_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d rd_cnt", i), 128'(a_rd_cnt), 128'(exp_rd));
            chk($sformatf("vec%0d wr_cnt", i), 128'(a_wr_cnt), 128'(exp_wr));
            chk($sformatf("vec%0d proto_err", i), 128'(a_perr), 128'(exp_perr));
        end

        // Reset while BUSY with cnt=3 during a write to 0x10
        @(negedge clk);
        a_write = 1'b1; a_addr = 28'h0000010; a_wdata = D7;
        repeat (5) @(posedge clk);
        #1;
        chk("busy no ready", 128'(a_ready), 128'(0));
        rst_a = 1'b1;
        #1;
        chk("midreset ready", 128'(a_ready), 128'(0));
        chk("midreset rdata", a_rdata, 128'd0);
        chk("midreset proto_err", 128'(a_perr), 128'(0));
        chk("midreset rd_cnt", 128'(a_rd_cnt), 128'(0));
        chk("midreset wr_cnt", 128'(a_wr_cnt), 128'(0));
        a_write = 1'b0;
        p0 = a_pulses;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("dropped write no pulse", 128'(a_pulses), 128'(p0));
        req(1'b0, 1'b1, 1'b0, 28'h0000010, D7, 8, "post_reset_read");
        chk("post_reset rdata", a_rdata, D6);
        chk("post_reset rd_cnt", 128'(a_rd_cnt), 128'(1));
        chk("post_reset wr_cnt", 128'(a_wr_cnt), 128'(0));
        chk("a total pulses", 128'(a_pulses), 128'(13));

        // LATENCY=1: request held through the HOLD cycle is not re-accepted
        @(negedge clk);
        b_read = 1'b1; b_addr = 28'h0000001;
        @(posedge clk); #1;
        chk("lat1 c1 ready", 128'(b_ready), 128'(1));
        @(posedge clk); #1;
        chk("lat1 c2 ready", 128'(b_ready), 128'(0));
        @(posedge clk); #1;
        b_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat1 idle%0d ready", k), 128'(b_ready), 128'(0));
        end
        chk("lat1 rd_cnt", 128'(b_rd_cnt), 128'(1));
        chk("lat1 pulses", 128'(b_pulses), 128'(1));

        // Saturation of a 4-bit read counter
        req(1'b1, 1'b0, 1'b1, 28'h0000007, D1, 1, "b_write");
        p0 = b_pulses;
        for (int k = 0; k < 17; k++) begin
            req(1'b1, 1'b1, 1'b0, 28'h0000007, D7, 1, $sformatf("b_read%0d", k));
            chk($sformatf("b_read%0d rdata", k), b_rdata, D1);
            chk($sformatf("b_read%0d rd_cnt", k), 128'(b_rd_cnt),
                128'((k + 2 > 15) ? 15 : k + 2));
        end
        chk("sat pulses", 128'(b_pulses - p0), 128'(17));
        chk("sat rd_cnt", 128'(b_rd_cnt), 128'(15));
        chk("sat wr_cnt", 128'(b_wr_cnt), 128'(1));
        chk("b proto_err", 128'(b_perr), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
